// File: rtl/grid_sequencer_if.sv
// rtl/grid_sequencer_if.sv - pixel streams, grid drive and status bundle for grid_sequencer (optional GRID_SEQ_FRAME_CNT_EN)
interface grid_sequencer_if;
  // input pixel stream and frame configuration
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  iter_count;
  // output pixel stream
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  // grid drive and grid last-cell readback
  logic [2:0]  operation;
  logic [7:0]  grid_data_in;
  logic [7:0]  grid_data_out;
  // status
  logic        busy;
  logic        frame_done;
`ifdef GRID_SEQ_FRAME_CNT_EN
  logic [15:0] frame_count;

  modport master (
    input  s_data, s_valid, iter_count, m_ready, grid_data_out,
    output s_ready, m_data, m_valid, operation, grid_data_in, busy, frame_done, frame_count
  );

  modport slave (
    output s_data, s_valid, iter_count, m_ready, grid_data_out,
    input  s_ready, m_data, m_valid, operation, grid_data_in, busy, frame_done, frame_count
  );
`else
  modport master (
    input  s_data, s_valid, iter_count, m_ready, grid_data_out,
    output s_ready, m_data, m_valid, operation, grid_data_in, busy, frame_done
  );

  modport slave (
    output s_data, s_valid, iter_count, m_ready, grid_data_out,
    input  s_ready, m_data, m_valid, operation, grid_data_in, busy, frame_done
  );
`endif
endinterface

// File: rtl/grid_sequencer.sv
// rtl/grid_sequencer.sv - load/step/unload sequencer for the CA pixel grid (optional GRID_SEQ_FRAME_CNT_EN adds frame_count)
module grid_sequencer #(
  parameter int         M        = 4,
  parameter int         N        = 4,
  parameter logic [2:0] OP_HOLD  = 3'd0,
  parameter logic [2:0] OP_SHIFT = 3'd1,
  parameter logic [2:0] OP_STEP  = 3'd2
) (
  input logic              clk,
  input logic              reset,
  grid_sequencer_if.master bus
);

  localparam int FRAME = M * N;
  localparam int CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]    iter_q, iter_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [2:0]    op_c;
  logic [7:0]    gdi_c;
  logic          s_ready_c;
  logic          slot_c;

  // Next-state logic and the combinational grid drive for the current phase
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    iter_d       = iter_q;
    m_data_d     = m_data_q;
    // a held output drops once the sink takes it, unless a new capture replaces it below
    m_valid_d    = m_valid_q && !bus.m_ready;
    frame_done_d = 1'b0;
    op_c         = OP_HOLD;
    gdi_c        = 8'h00;
    s_ready_c    = 1'b0;
    slot_c       = 1'b0;

    case (state_q)
      LOAD: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          op_c  = OP_SHIFT;
          gdi_c = bus.s_data;
          if (pix_cnt_q == LAST_IDX) begin
            pix_cnt_d = '0;
            iter_d    = bus.iter_count;
            state_d   = (bus.iter_count != 8'd0) ? RUN : UNLOAD;
          end else begin
            pix_cnt_d = pix_cnt_q + CW'(1);
          end
        end
      end

      RUN: begin
        op_c   = OP_STEP;
        iter_d = iter_q - 8'd1;
        // iter_q never reaches 0 here: a zero count bypasses RUN entirely
        if (iter_q <= 8'd1) begin
          state_d = UNLOAD;
        end
      end

      UNLOAD: begin
        slot_c = !m_valid_q || bus.m_ready;
        if (slot_c) begin
          // grid_data_out is the last cell before this shift lands
          op_c      = OP_SHIFT;
          m_data_d  = bus.grid_data_out;
          m_valid_d = 1'b1;
          if (pix_cnt_q == LAST_IDX) begin
            pix_cnt_d    = '0;
            state_d      = LOAD;
            frame_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    // the grid is cleared by the same reset, so nothing may be issued to it meanwhile
    if (reset) begin
      op_c      = OP_HOLD;
      gdi_c     = 8'h00;
      s_ready_c = 1'b1;
    end
  end

  // State, counters and the registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      pix_cnt_q    <= '0;
      iter_q       <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      iter_q       <= iter_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef GRID_SEQ_FRAME_CNT_EN
  logic [15:0] frame_count_q;

  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (frame_done_q) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.frame_count = frame_count_q;
`endif

  assign bus.operation    = op_c;
  assign bus.grid_data_in = gdi_c;
  assign bus.s_ready      = s_ready_c;
  assign bus.m_data       = m_data_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.busy         = (state_q != LOAD);
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_grid_sequencer.sv
// tb/tb_grid_sequencer.sv - self-checking bench for grid_sequencer with a behavioural grid
module tb_grid_sequencer;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_SHIFT = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;

  logic clk;
  logic reset;
  grid_sequencer_if bus ();

  grid_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural grid: a 16-cell shift chain; its CA rule is "every cell +1 per step",
  // so a frame run for n steps must come back as each input pixel plus n.
  logic [7:0] cells [16];
  assign bus.grid_data_out = cells[15];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) cells[i] <= 8'h00;
    end else if (bus.operation == OP_SHIFT) begin
      cells[0] <= bus.grid_data_in;
      for (int i = 1; i < 16; i++) cells[i] <= cells[i-1];
    end else if (bus.operation == OP_STEP) begin
      for (int i = 0; i < 16; i++) cells[i] <= cells[i] + 8'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  int frames_model = 0;
  logic [7:0] in_pix [16];
  logic [7:0] got_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0: full rate; 1: m_ready toggles in unload; 2: 3-cycle input gap at beat 7; 3: random
  task automatic load_phase(input int iter, input int mode);
    int k = 0;
    int cyc = 0;
    int gap = 0;
    while (k < 16 && cyc < 400) begin
      case (mode)
        2: begin
          if (k == 7 && gap < 3) begin bus.s_valid = 1'b0; gap++; end
          else bus.s_valid = 1'b1;
        end
        3: bus.s_valid = ($urandom_range(0, 3) != 0);
        default: bus.s_valid = 1'b1;
      endcase
      bus.s_data     = bus.s_valid ? in_pix[k] : 8'($urandom);
      bus.iter_count = (k == 15) ? 8'(iter) : 8'($urandom);
      bus.m_ready    = 1'b1;
      #4;
      chk("load_s_ready", bus.s_ready, 1);
      chk("load_busy", bus.busy, 0);
      if (bus.s_valid) begin
        chk("load_op_shift", bus.operation, OP_SHIFT);
        chk("load_gdi", bus.grid_data_in, in_pix[k]);
      end else begin
        chk("gap_op_hold", bus.operation, OP_HOLD);
        chk("gap_gdi", bus.grid_data_in, 0);
      end
      @(posedge clk); #1;
      if (bus.s_valid) k++;
      cyc++;
    end
    chk("load_beats", k, 16);
    bus.s_valid    = 1'b0;
    bus.iter_count = 8'($urandom);
  endtask

  task automatic run_phase(input int n);
    for (int i = 0; i < n; i++) begin
      #4;
      chk("run_op_step", bus.operation, OP_STEP);
      chk("run_busy", bus.busy, 1);
      chk("run_s_ready", bus.s_ready, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic unload_phase(input int iter, input int mode,
                              input logic [7:0] exp_first, input logic [7:0] exp_last,
                              input bit use_const);
    int shifts = 0;
    int cyc = 0;
    bit held_v = 1'b0;
    bit fd_next = 1'b0;
    bit slot;
    logic [7:0] held = 8'h00;
    logic [7:0] expv;
    got_q.delete();
    while ((shifts < 16 || bus.m_valid) && cyc < 400) begin
      case (mode)
        1: bus.m_ready = (cyc % 2 == 0);
        3: bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
      #4;
      if (held_v) chk("m_data_stable", bus.m_data, held);
      chk("frame_done", bus.frame_done, fd_next);
      slot = 1'b0;
      if (shifts < 16) begin
        slot = !bus.m_valid || bus.m_ready;
        chk("unload_op", bus.operation, slot ? OP_SHIFT : OP_HOLD);
        chk("unload_gdi", bus.grid_data_in, 0);
        chk("unload_busy", bus.busy, 1);
        if (mode == 0 && cyc == 0) chk("first_unload_m_valid", bus.m_valid, 0);
        if (mode == 0 && cyc == 1) chk("second_unload_m_valid", bus.m_valid, 1);
      end else begin
        chk("drain_op_hold", bus.operation, OP_HOLD);
        chk("drain_busy", bus.busy, 0);
      end
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      held_v  = bus.m_valid && !bus.m_ready;
      held    = bus.m_data;
      fd_next = slot && (shifts == 15);
      if (slot) shifts++;
      @(posedge clk); #1;
      cyc++;
    end
    frames_model++;
    chk("unload_shifts", shifts, 16);
    if (mode == 0) chk("unload_cycles", cyc, 17);
    chk("out_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      expv = in_pix[i] + 8'(iter);
      chk("out_pixel", got_q[i], expv);
    end
    if (use_const && got_q.size() == 16) begin
      chk("out_first", got_q[0], exp_first);
      chk("out_last", got_q[15], exp_last);
    end
`ifdef GRID_SEQ_FRAME_CNT_EN
    chk("frame_count", bus.frame_count, frames_model);
`endif
  endtask

  task automatic run_frame(input int iter, input int mode,
                           input logic [7:0] exp_first, input logic [7:0] exp_last,
                           input bit use_const);
    load_phase(iter, mode);
    run_phase(iter);
    unload_phase(iter, mode, exp_first, exp_last, use_const);
  endtask

  typedef struct {
    int         iter;
    int         mode;
    logic [7:0] base;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{iter: 0,   mode: 0, base: 8'h01, exp_first: 8'h01, exp_last: 8'h10};
    vecs[1] = '{iter: 5,   mode: 0, base: 8'h20, exp_first: 8'h25, exp_last: 8'h34};
    vecs[2] = '{iter: 1,   mode: 1, base: 8'hF8, exp_first: 8'hF9, exp_last: 8'h08};
    vecs[3] = '{iter: 3,   mode: 2, base: 8'h40, exp_first: 8'h43, exp_last: 8'h52};
    vecs[4] = '{iter: 255, mode: 0, base: 8'h00, exp_first: 8'hFF, exp_last: 8'h0E};

    reset          = 1'b1;
    bus.s_valid    = 1'b0;
    bus.s_data     = 8'h00;
    bus.iter_count = 8'h00;
    bus.m_ready    = 1'b1;
    @(posedge clk); #1;
    #4;
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_op", bus.operation, OP_HOLD);
    chk("rst_gdi", bus.grid_data_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
`ifdef GRID_SEQ_FRAME_CNT_EN
    chk("rst_frame_count", bus.frame_count, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[v]) begin
      for (int i = 0; i < 16; i++) in_pix[i] = vecs[v].base + 8'(i);
      run_frame(vecs[v].iter, vecs[v].mode, vecs[v].exp_first, vecs[v].exp_last, 1'b1);
    end

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) in_pix[i] = 8'($urandom);
      run_frame($urandom_range(0, 8), 3, 8'h00, 8'h00, 1'b0);
    end

    // reset lands on the second of five steps; the partial frame must vanish
    for (int i = 0; i < 16; i++) in_pix[i] = 8'h80 + 8'(i);
    load_phase(5, 0);
    run_phase(1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    chk("midrst_s_ready", bus.s_ready, 1);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_op", bus.operation, OP_HOLD);
    chk("midrst_busy", bus.busy, 0);
`ifdef GRID_SEQ_FRAME_CNT_EN
    chk("midrst_frame_count", bus.frame_count, 0);
`endif
    frames_model = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) in_pix[i] = 8'hA0 + 8'(i);
    run_frame(2, 0, 8'hA2, 8'hB1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
